sdram_pattern_tester: RTL and testbench

Self-checking traffic generator sitting directly upstream of the SDRAM controller's host port in the FPGA SDRAM test design. After reset it writes an address-derived pattern over [START_ADDR, END_ADDR], reads the same range back, and compares every returned word. The sticky results drive the board's complete/error LEDs.

---
 rtl/sdram_pattern_tester.sv | 119 +++++++++++
 tb/tb_sdram_pattern_tester.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester: writes an address-derived pattern over a word range, reads it back and checks it
// Ports: clk, rst_n (async active-low reset)
//        bus_req/bus_write/bus_addr/bus_wdata out, bus_ready in : host request port toward the SDRAM controller
//        bus_rvalid/bus_rdata in : in-order read responses
//        complete/error out : sticky status; err_addr : first mismatch address; err_count : saturating mismatch count
module sdram_pattern_tester #(
    parameter int              DW         = 16,
    parameter int              AW         = 23,
    parameter int unsigned     START_ADDR = 0,
    parameter int unsigned     END_ADDR   = 2**AW-1,
    parameter logic [DW-1:0]   KEY        = DW'(16'hA5C3),
    parameter int              MAX_OS     = 4,
    parameter int              TIMEOUT    = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          bus_req,
    output logic          bus_write,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ready,
    input  logic          bus_rvalid,
    input  logic [DW-1:0] bus_rdata,
    output logic          complete,
    output logic          error,
    output logic [AW-1:0] err_addr,
    output logic [15:0]   err_count
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] S_WRITE = 2'd0, S_READ = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        return DW'(a) ^ DW'(a >> DW) ^ KEY;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, chk_addr_q, chk_addr_d;
    logic [3:0]    os_q, os_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          req_q, req_d, write_q, write_d, complete_q, complete_d, error_q, error_d;
    logic [AW-1:0] addr_q, addr_d, err_addr_q, err_addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [15:0]   err_count_q, err_count_d;
    logic          xfer, rd_xfer, spur, chk, mism, tmo, wr_end, rd_end;

    always_comb begin
        xfer        = req_q && bus_ready;
        rd_xfer     = xfer && !write_q;
        spur        = bus_rvalid && os_q == '0;
        // late responses after a timeout are neither checked nor flagged
        chk         = bus_rvalid && !spur && (state_q == S_READ || state_q == S_DRAIN);
        mism        = chk && bus_rdata != pattern(chk_addr_q);
        os_d        = os_q + 4'(rd_xfer) - 4'(chk);
        timer_d     = (bus_rvalid || os_q == '0 || state_q == S_DONE) ? '0 : timer_q + TW'(1);
        tmo         = timer_d == TW'(TIMEOUT);
        // end compare comes before the increment so END_ADDR = 2**AW-1 never wraps
        wr_end      = wr_addr_q == AW'(END_ADDR);
        rd_end      = rd_addr_q == AW'(END_ADDR);
        wr_addr_d   = (state_q == S_WRITE && xfer && !wr_end) ? wr_addr_q + AW'(1) : wr_addr_q;
        rd_addr_d   = (state_q == S_READ && xfer && !rd_end) ? rd_addr_q + AW'(1) : rd_addr_q;
        chk_addr_d  = chk ? chk_addr_q + AW'(1) : chk_addr_q;
        state_d     = tmo ? S_DONE :
                      (state_q == S_WRITE && xfer && wr_end) ? S_READ :
                      (state_q == S_READ && xfer && rd_end) ? S_DRAIN :
                      (state_q == S_DRAIN && os_d == '0) ? S_DONE : state_q;
        // outputs are registered from next-state values; os_d is the count seen while the request is shown
        req_d       = state_d == S_WRITE || (state_d == S_READ && os_d < 4'(MAX_OS));
        write_d     = state_d == S_WRITE;
        addr_d      = state_d == S_WRITE ? wr_addr_d : state_d == S_READ ? rd_addr_d : addr_q;
        wdata_d     = write_d ? pattern(wr_addr_d) : wdata_q;
        complete_d  = state_d == S_DONE;
        error_d     = error_q || mism || spur || tmo;
        err_count_d = (mism && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
        err_addr_d  = (mism && err_count_q == '0) ? chk_addr_q : err_addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_WRITE;
            wr_addr_q   <= AW'(START_ADDR);
            rd_addr_q   <= AW'(START_ADDR);
            chk_addr_q  <= AW'(START_ADDR);
            os_q        <= '0;
            timer_q     <= '0;
            req_q       <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            complete_q  <= 1'b0;
            error_q     <= 1'b0;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            chk_addr_q  <= chk_addr_d;
            os_q        <= os_d;
            timer_q     <= timer_d;
            req_q       <= req_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            complete_q  <= complete_d;
            error_q     <= error_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus_req   = req_q;
    assign bus_write = write_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign complete  = complete_q;
    assign error     = error_q;
    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_sdram_pattern_tester.sv
// tb_sdram_pattern_tester: two tester instances (wide/narrow address, MAX_OS 4/2) against a queued memory model
module tb_sdram_pattern_tester;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int lat = 3, flip = -1, drop = -1;
    bit rnd = 1'b0, spur = 1'b0;

    logic        req_a [2], wr_a [2], cmp_a [2], er_a [2];
    logic [22:0] addr_a [2], eaddr_a [2];
    logic [15:0] wd_a [2], ecnt_a [2];
    int          wcnt [2][16];
    int          nrsp [2], fwr [2], lwr [2], lrv [2], dcyc [2], ecyc [2];

    task automatic chk(input string tag, input int g, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d]: observed %0d expected %0d", tag, g, obs, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int a, input int aw);
        return 16'(a) ^ 16'(aw > 16 ? a >> 16 : 0) ^ 16'hA5C3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int AWI = g ? 4 : 23;
        localparam int MOS = g ? 2 : 4;
        logic           rdy = 1'b1, rv = 1'b0, pwr;
        logic [15:0]    rd = '0, pwd;
        logic [AWI-1:0] addr, eaddr, paddr;
        int             q [$], due [$], mem [16];
        int             cyc, nwr, nrd, os, a;
        bit             pst, rvs;

        assign addr_a[g]  = 23'(addr);
        assign eaddr_a[g] = 23'(eaddr);

        sdram_pattern_tester #(.AW(AWI), .END_ADDR(15), .MAX_OS(MOS), .TIMEOUT(64)) u (
            .clk(clk), .rst_n(rst_n), .bus_req(req_a[g]), .bus_write(wr_a[g]), .bus_addr(addr),
            .bus_wdata(wd_a[g]), .bus_ready(rdy), .bus_rvalid(rv), .bus_rdata(rd),
            .complete(cmp_a[g]), .error(er_a[g]), .err_addr(eaddr), .err_count(ecnt_a[g]));

        always @(posedge clk) begin
            if (!rst_n) begin
                q.delete();
                due.delete();
                cyc = 0; nwr = 0; nrd = 0; os = 0; pst = 1'b0; rv = 1'b0; rvs = 1'b0; rdy = 1'b1;
                nrsp[g] = 0; fwr[g] = -1; lwr[g] = -1; lrv[g] = -1; dcyc[g] = -1; ecyc[g] = -1;
                for (int i = 0; i < 16; i++) wcnt[g][i] = 0;
            end else begin
                if (pst && req_a[g]) chk("stall_hold", g, {wr_a[g], addr, wd_a[g]}, {pwr, paddr, pwd});
                pst = req_a[g] && !rdy; pwr = wr_a[g]; paddr = addr; pwd = wd_a[g];
                if (rv && !rvs) begin os--; nrsp[g]++; lrv[g] = cyc; end
                if (req_a[g] && rdy) begin
                    if (wr_a[g]) begin
                        chk("wr_addr", g, addr, nwr);
                        chk("wr_data", g, wd_a[g], pat(int'(addr), AWI));
                        mem[addr] = int'(wd_a[g]);
                        wcnt[g][addr]++;
                        if (fwr[g] < 0) fwr[g] = cyc;
                        lwr[g] = cyc;
                        nwr++;
                    end else begin
                        chk("rd_addr", g, addr, nrd);
                        q.push_back(int'(addr));
                        due.push_back(cyc + lat);
                        nrd++; os++;
                        chk("os_cap", g, os <= MOS, 1);
                    end
                end
                if (cmp_a[g] && dcyc[g] < 0) dcyc[g] = cyc;
                if (er_a[g] && ecyc[g] < 0) ecyc[g] = cyc;
                if (cmp_a[g]) chk("req_after_done", g, req_a[g], 0);
                cyc++;
                #1;
                rdy = rnd ? ($urandom_range(0, 99) >= 30) : 1'b1;
                rv = 1'b0; rvs = 1'b0;
                if (spur) begin
                    rv = 1'b1; rvs = 1'b1;
                end else if (due.size() > 0 && due[0] <= cyc && !(drop >= 0 && q[0] >= drop)) begin
                    a = q.pop_front();
                    void'(due.pop_front());
                    rv = 1'b1;
                    rd = 16'(mem[a]) ^ 16'(a == flip);
                end
            end
        end
    end

    task automatic reset_chk(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk({tag, "_req"}, g, req_a[g], 0);
            chk({tag, "_write"}, g, wr_a[g], 0);
            chk({tag, "_addr"}, g, addr_a[g], 0);
            chk({tag, "_wdata"}, g, wd_a[g], 0);
            chk({tag, "_complete"}, g, cmp_a[g], 0);
            chk({tag, "_error"}, g, er_a[g], 0);
            chk({tag, "_err_addr"}, g, eaddr_a[g], 0);
            chk({tag, "_err_count"}, g, ecnt_a[g], 0);
        end
    endtask

    task automatic run(input int l, input bit r, input int f, input int d);
        lat = l; rnd = r; flip = f; drop = d;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3000 && !(cmp_a[0] && cmp_a[1]); i++) @(negedge clk);
        chk("finish", 0, cmp_a[0] && cmp_a[1], 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic expect_res(input string tag, input bit er, input int ec, input int ea, input int nr, input bit tmo);
        for (int g = 0; g < 2; g++) begin
            int once = 0;
            for (int i = 0; i < 16; i++) once += int'(wcnt[g][i] == 1);
            chk({tag, "_complete"}, g, cmp_a[g], 1);
            chk({tag, "_error"}, g, er_a[g], er);
            chk({tag, "_err_count"}, g, ecnt_a[g], ec);
            chk({tag, "_err_addr"}, g, eaddr_a[g], ea);
            chk({tag, "_written_once"}, g, once, 16);
            chk({tag, "_responses"}, g, nrsp[g], nr);
            if (tmo) begin
                chk({tag, "_timeout_cycle"}, g, ecyc[g], lrv[g] + 65);
                chk({tag, "_done_with_err"}, g, dcyc[g], ecyc[g]);
            end else chk({tag, "_done_cycle"}, g, dcyc[g], lrv[g] + 1);
            if (!rnd) begin
                chk({tag, "_first_write"}, g, fwr[g], 1);
                chk({tag, "_last_write"}, g, lwr[g], 16);
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_chk("reset");

        run(3, 1'b0, -1, -1);
        expect_res("clean", 1'b0, 0, 0, 16, 1'b0);

        @(negedge clk) spur = 1'b1;
        @(negedge clk) spur = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("spur_error", g, er_a[g], 1);
            chk("spur_count", g, ecnt_a[g], 0);
            chk("spur_complete", g, cmp_a[g], 1);
        end

        run(3, 1'b0, 5, -1);
        expect_res("flip5", 1'b1, 1, 5, 16, 1'b0);

        run(3, 1'b1, -1, -1);
        expect_res("stall", 1'b0, 0, 0, 16, 1'b0);

        run(6, 1'b0, -1, -1);
        expect_res("lat6", 1'b0, 0, 0, 16, 1'b0);

        run(3, 1'b0, -1, 9);
        expect_res("hang9", 1'b1, 0, 0, 9, 1'b1);

        lat = 3; rnd = 1'b0; flip = -1; drop = -1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 100 && !(req_a[0] && wr_a[0] && addr_a[0] == 23'd7); i++) @(negedge clk);
        chk("reach_addr7", 0, addr_a[0], 7);
        #2 rst_n = 1'b0;
        #1 reset_chk("midrst");
        run(3, 1'b0, -1, -1);
        expect_res("restart", 1'b0, 0, 0, 16, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
